// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, tx handshake widths and the word-sender FSM encoding.
// Imported by uart_word_sender, its interface and the UART top so all agree on widths.
package uart_pkg;

   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned TX_DATA_W  = BYTE_W;
   localparam int unsigned TX_START_W = 1;
   localparam int unsigned TX_READY_W = 1;

   // ST_CSUM is only reachable when UART_WORD_CHECKSUM_EN is defined
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SEND      = 3'd1,
      ST_WAIT_ACK  = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_CSUM      = 3'd4
   } state_e;

endpackage

// File: rtl/uart_word_sender_if.sv
// Word-in / byte-out handshake bundle for uart_word_sender.
//   word_valid/word_data/word_ready : upstream word handshake (e.g. RSA result)
//   tx_start/tx_data/tx_ready       : downstream UART transmitter handshake
//   busy                            : word in progress
// Modports: slave = the sender block, master = its environment.
interface uart_word_sender_if
   import uart_pkg::*;
#(
   parameter int unsigned WORD_W = 32
);

   logic                    word_valid;
   logic [WORD_W-1:0]       word_data;
   logic                    word_ready;
   logic [TX_START_W-1:0]   tx_start;
   logic [TX_DATA_W-1:0]    tx_data;
   logic [TX_READY_W-1:0]   tx_ready;
   logic                    busy;

   modport slave (
      input  word_valid, word_data, tx_ready,
      output word_ready, tx_start, tx_data, busy
   );

   modport master (
      output word_valid, word_data, tx_ready,
      input  word_ready, tx_start, tx_data, busy
   );

endinterface

// File: rtl/uart_word_sender.sv
// uart_word_sender: accepts one WORD_W-bit word and feeds it, LSB byte first,
// to a UART transmitter one byte per tx_start/tx_ready handshake.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset (aborts any word in flight)
//   bus  - uart_word_sender_if.slave (word handshake, tx handshake, busy)
// Parameter WORD_W: multiple of 8, >= 8.
// Macro UART_WORD_CHECKSUM_EN: when defined, an XOR-of-all-bytes checksum byte
// follows the data bytes of every word.
module uart_word_sender
   import uart_pkg::*;
#(
   parameter int unsigned WORD_W = 32
)
(
   input  logic                clk,
   input  logic                rst,
   uart_word_sender_if.slave   bus
);

   localparam int unsigned NBYTES = WORD_W / BYTE_W;
   localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   state_e                 state_q, state_d;
   logic [WORD_W-1:0]      shift_q, shift_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [TX_DATA_W-1:0]   tx_data_q, tx_data_d;
   logic                   tx_start_q, tx_start_d;
   logic                   word_ready_q, word_ready_d;
`ifdef UART_WORD_CHECKSUM_EN
   logic [BYTE_W-1:0]      xor_q, xor_d;
   logic                   csum_q, csum_d;   // checksum byte is the one in flight
`endif

   // next-state and output logic
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
`ifdef UART_WORD_CHECKSUM_EN
      xor_d      = xor_q;
      csum_d     = csum_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.word_valid && word_ready_q) begin
               shift_d = bus.word_data;
               cnt_d   = '0;
`ifdef UART_WORD_CHECKSUM_EN
               xor_d   = '0;
               csum_d  = 1'b0;
`endif
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (bus.tx_ready[0]) begin
               tx_start_d = 1'b1;
               tx_data_d  = shift_q[BYTE_W-1:0];
`ifdef UART_WORD_CHECKSUM_EN
               xor_d      = xor_q ^ shift_q[BYTE_W-1:0];
`endif
               state_d    = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            // transmitter drops tx_ready once it has taken the byte
            if (!bus.tx_ready[0]) state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (bus.tx_ready[0]) begin
`ifdef UART_WORD_CHECKSUM_EN
               if (csum_q) begin
                  state_d = ST_IDLE;
               end else
`endif
               begin
                  shift_d = shift_q >> BYTE_W;
                  if (cnt_q == CNT_W'(NBYTES - 1)) begin
`ifdef UART_WORD_CHECKSUM_EN
                     state_d = ST_CSUM;
`else
                     state_d = ST_IDLE;
`endif
                  end else begin
                     cnt_d   = CNT_W'(cnt_q + 1'b1);
                     state_d = ST_SEND;
                  end
               end
            end
         end
`ifdef UART_WORD_CHECKSUM_EN
         ST_CSUM: begin
            if (bus.tx_ready[0]) begin
               tx_start_d = 1'b1;
               tx_data_d  = xor_q;
               csum_d     = 1'b1;
               state_d    = ST_WAIT_ACK;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
      word_ready_d = (state_d == ST_IDLE);
   end

   // state and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         shift_q      <= '0;
         cnt_q        <= '0;
         tx_data_q    <= '0;
         tx_start_q   <= 1'b0;
         word_ready_q <= 1'b1;
`ifdef UART_WORD_CHECKSUM_EN
         xor_q        <= '0;
         csum_q       <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         cnt_q        <= cnt_d;
         tx_data_q    <= tx_data_d;
         tx_start_q   <= tx_start_d;
         word_ready_q <= word_ready_d;
`ifdef UART_WORD_CHECKSUM_EN
         xor_q        <= xor_d;
         csum_q       <= csum_d;
`endif
      end
   end

   assign bus.word_ready = word_ready_q;
   assign bus.busy       = ~word_ready_q;
   assign bus.tx_start   = TX_START_W'(tx_start_q);
   assign bus.tx_data    = tx_data_q;

endmodule

// File: tb/tb_uart_word_sender.sv
// Directed bench for uart_word_sender: a 32-bit and an 8-bit instance, each with
// a small UART transmitter model that drops tx_ready for a few cycles per byte.
module tb_uart_word_sender;
   import uart_pkg::*;

`ifdef UART_WORD_CHECKSUM_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif

   logic clk;
   logic rst32, rst8;
   int   nchk = 0;
   int   nbad = 0;

   uart_word_sender_if #(.WORD_W(32)) if32 ();
   uart_word_sender_if #(.WORD_W(8))  if8  ();

   uart_word_sender #(.WORD_W(32)) dut32 (.clk(clk), .rst(rst32), .bus(if32));
   uart_word_sender #(.WORD_W(8))  dut8  (.clk(clk), .rst(rst8),  .bus(if8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // transmitter models: record bytes, flag protocol violations
   logic [7:0] got32[$];
   logic [7:0] got8[$];
   int   busy32 = 0, busy8 = 0;
   int   viol32 = 0, viol8 = 0;
   logic prev32 = 1'b0, prev8 = 1'b0;
   logic hold32 = 1'b0;

   always @(negedge clk) begin
      if (rst32) begin
         if32.tx_ready = 1'b1;
         busy32 = 0;
      end else if (if32.tx_start[0]) begin
         if (!if32.tx_ready[0] || prev32) viol32++;
         got32.push_back(if32.tx_data);
         if32.tx_ready = 1'b0;
         busy32 = 3;
      end else if (busy32 > 0) begin
         busy32--;
      end else begin
         if32.tx_ready = !hold32;
      end
      prev32 = if32.tx_start[0];
   end

   always @(negedge clk) begin
      if (rst8) begin
         if8.tx_ready = 1'b1;
         busy8 = 0;
      end else if (if8.tx_start[0]) begin
         if (!if8.tx_ready[0] || prev8) viol8++;
         got8.push_back(if8.tx_data);
         if8.tx_ready = 1'b0;
         busy8 = 2;
      end else if (busy8 > 0) begin
         busy8--;
      end else begin
         if8.tx_ready = 1'b1;
      end
      prev8 = if8.tx_start[0];
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // compare recorded bytes from index base against exp, byte 0 first
   task automatic check_bytes(input string tag, input logic [7:0] q[$], input int base,
                              input logic [39:0] exp, input int n);
      chk({tag, "_count"}, 64'(q.size() - base), 64'(n));
      for (int i = 0; i < n; i++)
         if (base + i < q.size()) chk($sformatf("%s_b%0d", tag, i), 64'(q[base + i]), 64'(exp[8*i +: 8]));
   endtask

   task automatic send32(input logic [31:0] w);
      int t = 0;
      while (!if32.word_ready && t < 500) begin @(negedge clk); t++; end
      if (t >= 500) chk("send32_timeout", 0, 1);
      if32.word_valid = 1'b1;
      if32.word_data  = w;
      @(negedge clk);
      if32.word_valid = 1'b0;
   endtask

   task automatic send8(input logic [7:0] w);
      int t = 0;
      while (!if8.word_ready && t < 500) begin @(negedge clk); t++; end
      if (t >= 500) chk("send8_timeout", 0, 1);
      if8.word_valid = 1'b1;
      if8.word_data  = w;
      @(negedge clk);
      if8.word_valid = 1'b0;
   endtask

   task automatic wait_idle32();
      int t = 0;
      while (!if32.word_ready && t < 500) begin @(negedge clk); t++; end
      chk("idle32_in_time", 64'(t < 500), 1);
   endtask

   task automatic wait_idle8();
      int t = 0;
      while (!if8.word_ready && t < 500) begin @(negedge clk); t++; end
      chk("idle8_in_time", 64'(t < 500), 1);
   endtask

   initial begin
      int   base;
      int   t;
      logic seen_ready;

      if32.word_valid = 1'b0; if32.word_data = '0;
      if8.word_valid  = 1'b0; if8.word_data  = '0;
      rst32 = 1'b1; rst8 = 1'b1;
      repeat (3) @(negedge clk);

      // reset values
      chk("rst_word_ready", 64'(if32.word_ready), 1);
      chk("rst_busy",       64'(if32.busy), 0);
      chk("rst_tx_start",   64'(if32.tx_start), 0);
      chk("rst_tx_data",    64'(if32.tx_data), 0);
      rst32 = 1'b0; rst8 = 1'b0;
      @(negedge clk);

      // 1: DEADBEEF -> EF BE AD DE (+ checksum 22), first start one cycle after accept
      base = got32.size();
      send32(32'hDEADBEEF);
      chk("t1_busy", 64'(if32.busy), 1);
      @(negedge clk);
      chk("t1_latency_start", 64'(if32.tx_start), 1);
      chk("t1_latency_data",  64'(if32.tx_data), 8'hEF);
      wait_idle32();
      check_bytes("t1", got32, base, {8'h22, 32'hDEADBEEF}, 4 + EXTRA);
      chk("t1_ready_back", 64'(if32.word_ready), 1);

      // 2: transmitter not ready for 50 cycles after accept
      hold32 = 1'b1;
      repeat (2) @(negedge clk);
      base = got32.size();
      send32(32'hDEADBEEF);
      repeat (50) @(negedge clk);
      chk("t2_no_start_while_held", 64'(got32.size() - base), 0);
      hold32 = 1'b0;
      t = 0;
      while (got32.size() == base && t < 20) begin @(negedge clk); t++; end
      chk("t2_start_after_release", 64'(got32.size() - base), 1);
      wait_idle32();
      check_bytes("t2", got32, base, {8'h22, 32'hDEADBEEF}, 4 + EXTRA);

      // 3: second word offered while busy is ignored
      base = got32.size();
      send32(32'hDEADBEEF);
      seen_ready = 1'b0;
      if32.word_valid = 1'b1;
      if32.word_data  = 32'h12345678;
      repeat (10) begin
         @(negedge clk);
         if (if32.word_ready) seen_ready = 1'b1;
      end
      if32.word_valid = 1'b0;
      chk("t3_ready_low_while_busy", 64'(seen_ready), 0);
      wait_idle32();
      repeat (20) @(negedge clk);
      check_bytes("t3", got32, base, {8'h22, 32'hDEADBEEF}, 4 + EXTRA);

      // 4: reset after the 2nd byte starts, then a fresh word
      base = got32.size();
      send32(32'hDEADBEEF);
      t = 0;
      while (got32.size() - base < 2 && t < 200) begin @(negedge clk); t++; end
      chk("t4_two_bytes_before_rst", 64'(got32.size() - base), 2);
      rst32 = 1'b1;
      @(negedge clk);
      chk("t4_rst_tx_start",   64'(if32.tx_start), 0);
      chk("t4_rst_tx_data",    64'(if32.tx_data), 0);
      chk("t4_rst_word_ready", 64'(if32.word_ready), 1);
      chk("t4_rst_busy",       64'(if32.busy), 0);
      rst32 = 1'b0;
      @(negedge clk);
      base = got32.size();
      send32(32'h00000001);
      wait_idle32();
      repeat (10) @(negedge clk);
      check_bytes("t4", got32, base, {8'h01, 32'h00000001}, 4 + EXTRA);

      // 5: 01020304 -> 04 03 02 01 (+ checksum 04)
      base = got32.size();
      send32(32'h01020304);
      wait_idle32();
      repeat (10) @(negedge clk);
      check_bytes("t5", got32, base, {8'h04, 32'h01020304}, 4 + EXTRA);

      // 6: 8-bit word, then two back-to-back words
      base = got8.size();
      send8(8'hA5);
      wait_idle8();
      repeat (5) @(negedge clk);
      check_bytes("t6_single", got8, base, 40'hA5A5, 1 + EXTRA);
      base = got8.size();
      send8(8'h3C);
      send8(8'hC3);
      wait_idle8();
      repeat (10) @(negedge clk);
      if (EXTRA != 0) check_bytes("t6_b2b", got8, base, 40'hC3C33C3C, 4);
      else            check_bytes("t6_b2b", got8, base, 40'hC33C, 2);

      chk("protocol32", 64'(viol32), 0);
      chk("protocol8",  64'(viol8), 0);

      $display("test done: total=%0d bad=%0d", nchk, nbad);
      $finish;
   end

endmodule
